// File: rtl/ir_move_scheduler_if.sv
// Handshake bundle between the main FSM / IR transmitter and the move scheduler.
interface ir_move_scheduler_if;
  logic        start;
  logic [11:0] move_command;
  logic        abort;
  logic        ir_ready;
  logic        ir_send;
  logic [11:0] ir_data;
  logic        busy;
  logic        move_done;
  logic        aborted;
  logic        tx_error;
  logic [3:0]  repeats_sent;
  logic [2:0]  state;

  modport master (
    output start, move_command, abort, ir_ready,
    input  ir_send, ir_data, busy, move_done, aborted, tx_error, repeats_sent, state
  );

  modport slave (
    input  start, move_command, abort, ir_ready,
    output ir_send, ir_data, busy, move_done, aborted, tx_error, repeats_sent, state
  );
endinterface

// File: rtl/ir_move_scheduler.sv
// IR move scheduler: latches one 12-bit move command, transmits it a fixed
// number of times with idle gaps in between, then times the physical move
// and pulses move_done. abort cancels from any busy state.
module ir_move_scheduler #(
  parameter int unsigned REPEAT_COUNT   = 5,
  parameter int unsigned GAP_CYCLES     = 1000000,
  parameter int unsigned TX_TIMEOUT     = 5000000,
  parameter int unsigned TICKS_PER_UNIT = 27000000,
  parameter int unsigned SETTLE_UNITS   = 1
) (
  input logic                clock,
  input logic                reset_n,
  ir_move_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_WAIT_TX = 3'd2,
    S_GAP     = 3'd3,
    S_MOVE    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // One shared counter serves the TX timeout, the gap and the per-unit ticks;
  // it only ever needs to reach the largest of the three limits minus one.
  localparam int unsigned MAX_AB  = (TX_TIMEOUT > GAP_CYCLES) ? TX_TIMEOUT : GAP_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_AB > TICKS_PER_UNIT) ? MAX_AB : TICKS_PER_UNIT;
  localparam int          CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        cnt_ext;
  logic [8:0]         units_q, units_d;
  logic               seen_low_q, seen_low_d;
  logic [3:0]         rep_q, rep_d, rep_inc;
  logic [11:0]        data_q, data_d;
  logic               tx_err_q, tx_err_d;
  logic               send_q, send_d;
  logic               aborted_q, aborted_d;
  logic               done_q, busy_q;
  logic               tx_end;

  assign cnt_ext = 32'(cnt_q);

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and next-output decode; abort in any busy state has priority.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    units_d    = units_q;
    seen_low_d = seen_low_q;
    rep_d      = rep_q;
    tx_err_d   = tx_err_q;
    data_d     = data_q;
    send_d     = 1'b0;
    aborted_d  = 1'b0;
    tx_end     = 1'b0;
    rep_inc    = rep_q + 4'd1;
    if ((state_q != S_IDLE) && bus.abort) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            data_d   = bus.move_command;
            rep_d    = 4'd0;
            tx_err_d = 1'b0;
            cnt_d    = '0;
            state_d  = S_SEND;
          end
        end
        S_SEND: begin
          if (bus.ir_ready) begin
            send_d     = 1'b1;
            cnt_d      = '0;
            seen_low_d = 1'b0;
            state_d    = S_WAIT_TX;
          end
        end
        S_WAIT_TX: begin
          // A transmission is complete once ready has gone low and come back.
          if (seen_low_q && bus.ir_ready) begin
            tx_end = 1'b1;
          end else if (cnt_ext + 32'd1 >= TX_TIMEOUT) begin
            tx_end   = 1'b1;
            tx_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!bus.ir_ready) seen_low_d = 1'b1;
          end
          if (tx_end) begin
            rep_d = rep_inc;
            cnt_d = '0;
            if (rep_inc == 4'(REPEAT_COUNT)) begin
              units_d = 9'(data_q[11:8]) + 9'(data_q[7:0]) + 9'(SETTLE_UNITS);
              state_d = S_MOVE;
            end else begin
              state_d = S_GAP;
            end
          end
        end
        S_GAP: begin
          if (cnt_ext + 32'd1 >= GAP_CYCLES) begin
            cnt_d   = '0;
            state_d = S_SEND;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_MOVE: begin
          if (units_q == 9'd0) begin
            state_d = S_DONE;
          end else if (cnt_ext + 32'd1 >= TICKS_PER_UNIT) begin
            cnt_d   = '0;
            units_d = units_q - 9'd1;
            if (units_q == 9'd1) state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      units_q    <= 9'd0;
      seen_low_q <= 1'b0;
      rep_q      <= 4'd0;
      data_q     <= 12'd0;
      tx_err_q   <= 1'b0;
      send_q     <= 1'b0;
      aborted_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      units_q    <= units_d;
      seen_low_q <= seen_low_d;
      rep_q      <= rep_d;
      data_q     <= data_d;
      tx_err_q   <= tx_err_d;
      send_q     <= send_d;
      aborted_q  <= aborted_d;
      done_q     <= (state_d == S_DONE);
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign bus.ir_send      = send_q;
  assign bus.ir_data      = data_q;
  assign bus.busy         = busy_q;
  assign bus.move_done    = done_q;
  assign bus.aborted      = aborted_q;
  assign bus.tx_error     = tx_err_q;
  assign bus.repeats_sent = rep_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_ir_move_scheduler.sv
// Directed bench for ir_move_scheduler with an IR transmitter model and a
// scoreboard of expected move_done/aborted events.
module tb_ir_move_scheduler;
  localparam int unsigned REP = 3;
  localparam int unsigned GAP = 4;
  localparam int unsigned TMO = 50;
  localparam int unsigned TPU = 10;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SEND = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_MOVE = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  typedef struct {
    logic        is_done;
    logic [11:0] data;
    logic [3:0]  reps;
    logic        tx_err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic stuck = 1'b0;
  int   cyc   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  exp_t sb[$];
  int   send_cyc[$];
  int   send_cnt = 0, done_cnt = 0, abort_cnt = 0, done_cyc = 0, move_cyc = 0;
  logic [2:0] prev_state = 3'd0;

  ir_move_scheduler_if bus_a ();
  ir_move_scheduler_if bus_b ();

  ir_move_scheduler #(
    .REPEAT_COUNT(REP), .GAP_CYCLES(GAP), .TX_TIMEOUT(TMO),
    .TICKS_PER_UNIT(TPU), .SETTLE_UNITS(1)
  ) dut_a (.clock(clk), .reset_n(rst_n), .bus(bus_a));

  ir_move_scheduler #(
    .REPEAT_COUNT(REP), .GAP_CYCLES(GAP), .TX_TIMEOUT(TMO),
    .TICKS_PER_UNIT(TPU), .SETTLE_UNITS(0)
  ) dut_b (.clock(clk), .reset_n(rst_n), .bus(bus_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, observed no end of test, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // IR transmitter: ready drops one cycle after a strobe and returns 8 later.
  initial begin
    bus_a.ir_ready = 1'b1;
    bus_b.ir_ready = 1'b1;
    forever begin
      @(negedge clk);
      if ((bus_a.ir_send === 1'b1 || bus_b.ir_send === 1'b1) && !stuck) begin
        @(negedge clk);
        bus_a.ir_ready = 1'b0;
        bus_b.ir_ready = 1'b0;
        repeat (8) @(negedge clk);
        bus_a.ir_ready = 1'b1;
        bus_b.ir_ready = 1'b1;
      end
    end
  end

  // Monitor on dut_a: event timestamps and scoreboard pops.
  always @(negedge clk) begin
    exp_t e;
    if (bus_a.ir_send === 1'b1) begin
      send_cnt++;
      send_cyc.push_back(cyc);
    end
    if (bus_a.state == ST_MOVE && prev_state != ST_MOVE) move_cyc = cyc;
    prev_state = bus_a.state;
    if (bus_a.move_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus_a.aborted === 1'b1) abort_cnt++;
    if (bus_a.move_done === 1'b1 || bus_a.aborted === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_event", {bus_a.move_done, bus_a.aborted}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_kind", {bus_a.move_done, bus_a.aborted}, e.is_done ? 32'd2 : 32'd1);
        check("sb_ir_data", bus_a.ir_data, e.data);
        check("sb_repeats", bus_a.repeats_sent, e.reps);
        check("sb_tx_error", bus_a.tx_error, e.tx_err);
      end
    end
  end

  function automatic int sc(input int i);
    return (i < send_cyc.size()) ? send_cyc[i] : -1000;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic is_done, input logic [11:0] data,
                          input logic [3:0] reps, input logic tx_err);
    exp_t e;
    e.is_done = is_done;
    e.data    = data;
    e.reps    = reps;
    e.tx_err  = tx_err;
    sb.push_back(e);
  endtask

  task automatic start_a(input logic [11:0] cmd);
    bus_a.move_command = cmd;
    bus_a.start        = 1'b1;
    tick(1);
    bus_a.start        = 1'b0;
  endtask

  task automatic wait_a_state(input logic [2:0] s, input int limit, input string tag);
    int n = 0;
    while (bus_a.state !== s && n < limit) begin
      tick(1);
      n++;
    end
    check(tag, bus_a.state, s);
  endtask

  task automatic wait_a_idle(input int limit, input string tag);
    int n = 0;
    while (bus_a.busy !== 1'b0 && n < limit) begin
      tick(1);
      n++;
    end
    check(tag, bus_a.busy, 1'b0);
  endtask

  task automatic run_nominal(input string tag);
    int d0;
    d0 = done_cnt;
    send_cyc.delete();
    push_exp(1'b1, 12'h20A, 4'd3, 1'b0);
    start_a(12'h20A);
    check({tag, "_ir_data"}, bus_a.ir_data, 12'h20A);
    check({tag, "_busy"}, bus_a.busy, 1'b1);
    check({tag, "_state_send"}, bus_a.state, ST_SEND);
    bus_a.move_command = 12'hFFF;
    wait_a_idle(400, {tag, "_finish"});
    check({tag, "_send_count"}, send_cyc.size(), 32'd3);
    check({tag, "_spacing1"}, 32'(sc(1) - sc(0)), 32'd15);
    check({tag, "_spacing2"}, 32'(sc(2) - sc(1)), 32'd15);
    check({tag, "_move_len"}, 32'(done_cyc - move_cyc), 32'd130);
    check({tag, "_send_to_done"}, 32'(done_cyc - sc(2)), 32'd140);
    check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_repeats"}, bus_a.repeats_sent, 4'd3);
    check({tag, "_tx_error"}, bus_a.tx_error, 1'b0);
    check({tag, "_ir_data_hold"}, bus_a.ir_data, 12'h20A);
  endtask

  initial begin
    int s0, d0, a0, n;
    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.move_command = 12'h000;
    bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.move_command = 12'h000;

    // Reset state
    tick(2);
    check("reset_outputs_a", {bus_a.ir_send, bus_a.ir_data, bus_a.busy, bus_a.move_done,
          bus_a.aborted, bus_a.tx_error, bus_a.repeats_sent, bus_a.state}, 32'd0);
    check("reset_state_b", bus_b.state, ST_IDLE);
    rst_n = 1'b1;
    tick(2);

    // Nominal sequence
    run_nominal("nominal");

    // Zero-length move on the SETTLE_UNITS=0 instance
    bus_b.move_command = 12'h000;
    bus_b.start = 1'b1;
    tick(1);
    bus_b.start = 1'b0;
    n = 0;
    while (bus_b.state !== ST_MOVE && n < 200) begin
      tick(1);
      n++;
    end
    check("zero_move_entry", bus_b.state, ST_MOVE);
    tick(1);
    check("zero_done_state", bus_b.state, ST_DONE);
    check("zero_move_done", bus_b.move_done, 1'b1);
    tick(1);
    check("zero_busy_after", bus_b.busy, 1'b0);
    check("zero_done_single", bus_b.move_done, 1'b0);

    // Stuck transmitter: every send times out, move still runs
    stuck = 1'b1;
    send_cyc.delete();
    push_exp(1'b1, 12'h105, 4'd3, 1'b1);
    start_a(12'h105);
    wait_a_idle(600, "stuck_finish");
    check("stuck_send_count", send_cyc.size(), 32'd3);
    check("stuck_spacing1", 32'(sc(1) - sc(0)), 32'd55);
    check("stuck_spacing2", 32'(sc(2) - sc(1)), 32'd55);
    check("stuck_move_len", 32'(done_cyc - move_cyc), 32'd70);
    check("stuck_tx_error", bus_a.tx_error, 1'b1);
    check("stuck_repeats", bus_a.repeats_sent, 4'd3);
    stuck = 1'b0;

    // Next start clears tx_error; one-unit move
    push_exp(1'b1, 12'h000, 4'd3, 1'b0);
    start_a(12'h000);
    check("clear_tx_error", bus_a.tx_error, 1'b0);
    wait_a_idle(400, "unit_finish");
    check("unit_move_len", 32'(done_cyc - move_cyc), 32'd10);

    // Abort during GAP
    push_exp(1'b0, 12'h3C1, 4'd1, 1'b0);
    start_a(12'h3C1);
    wait_a_state(ST_GAP, 100, "gap_reached");
    s0 = send_cnt; d0 = done_cnt; a0 = abort_cnt;
    bus_a.abort = 1'b1;
    tick(1);
    bus_a.abort = 1'b0;
    check("gap_abort_state", bus_a.state, ST_IDLE);
    check("gap_abort_busy", bus_a.busy, 1'b0);
    check("gap_abort_pulse", bus_a.aborted, 1'b1);
    check("gap_abort_ir_send", bus_a.ir_send, 1'b0);
    tick(30);
    check("gap_abort_no_send", send_cnt, s0);
    check("gap_abort_no_done", done_cnt, d0);
    check("gap_abort_once", 32'(abort_cnt - a0), 32'd1);
    check("gap_abort_ir_data", bus_a.ir_data, 12'h3C1);
    check("gap_abort_repeats", bus_a.repeats_sent, 4'd1);

    // Abort during MOVE
    push_exp(1'b0, 12'h0FF, 4'd3, 1'b0);
    start_a(12'h0FF);
    wait_a_state(ST_MOVE, 100, "move_reached");
    tick(5);
    s0 = send_cnt; d0 = done_cnt; a0 = abort_cnt;
    bus_a.abort = 1'b1;
    tick(1);
    bus_a.abort = 1'b0;
    check("move_abort_state", bus_a.state, ST_IDLE);
    check("move_abort_busy", bus_a.busy, 1'b0);
    check("move_abort_pulse", bus_a.aborted, 1'b1);
    tick(30);
    check("move_abort_no_send", send_cnt, s0);
    check("move_abort_no_done", done_cnt, d0);
    check("move_abort_once", 32'(abort_cnt - a0), 32'd1);
    check("move_abort_repeats", bus_a.repeats_sent, 4'd3);

    // Same-cycle start and abort in IDLE
    s0 = send_cnt; a0 = abort_cnt;
    bus_a.move_command = 12'h555;
    bus_a.start = 1'b1;
    bus_a.abort = 1'b1;
    tick(1);
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    check("start_abort_state", bus_a.state, ST_IDLE);
    check("start_abort_busy", bus_a.busy, 1'b0);
    check("start_abort_ir_data", bus_a.ir_data, 12'h0FF);
    tick(5);
    check("start_abort_no_send", send_cnt, s0);
    check("start_abort_no_pulse", abort_cnt, a0);

    // Start while busy, and start in the DONE cycle, are ignored
    push_exp(1'b1, 12'h111, 4'd3, 1'b0);
    start_a(12'h111);
    wait_a_state(ST_WAIT, 50, "busy_wait_reached");
    bus_a.move_command = 12'hABC;
    bus_a.start = 1'b1;
    tick(1);
    bus_a.start = 1'b0;
    check("busy_start_ir_data", bus_a.ir_data, 12'h111);
    check("busy_start_busy", bus_a.busy, 1'b1);
    n = 0;
    while (bus_a.move_done !== 1'b1 && n < 400) begin
      tick(1);
      n++;
    end
    check("busy_done_seen", bus_a.move_done, 1'b1);
    check("busy_move_len", 32'(done_cyc - move_cyc), 32'd190);
    bus_a.move_command = 12'h777;
    bus_a.start = 1'b1;
    tick(1);
    bus_a.start = 1'b0;
    check("done_start_state", bus_a.state, ST_IDLE);
    check("done_start_busy", bus_a.busy, 1'b0);
    tick(3);
    check("done_start_still_idle", bus_a.busy, 1'b0);
    check("done_start_ir_data", bus_a.ir_data, 12'h111);

    // Asynchronous reset mid-MOVE
    d0 = done_cnt; a0 = abort_cnt;
    start_a(12'h20A);
    wait_a_state(ST_MOVE, 100, "reset_move_reached");
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {bus_a.ir_send, bus_a.ir_data, bus_a.busy, bus_a.move_done,
          bus_a.aborted, bus_a.tx_error, bus_a.repeats_sent, bus_a.state}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("reset_no_done", done_cnt, d0);
    check("reset_no_abort", abort_cnt, a0);

    // Fresh nominal run after reset
    run_nominal("post_reset");

    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
